div4_seq: RTL and testbench



---
 rtl/div4_seq_pkg.sv | 44 ++++
 rtl/div4_seq_addsub.sv | 42 ++++
 rtl/div4_seq.sv | 145 ++++++++++++++
 tb/tb_div4_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/div4_seq_pkg.sv
// ---------------------------------------------------------------------------
// div4_seq_pkg
//   Shared definitions for the sequential 4-bit restoring divider and the
//   ripple add/subtract unit it drives.
//
//   Contents:
//     DIV_WIDTH          operand width (fixed at 4 to match adder_cum_sub)
//     IDLE/RUN/DONE      controller state encoding
//     ZERO_DIV_QUOTIENT  quotient reported for a zero divisor
//     div_result_t       bundle of the values returned to the consumer
//     trial_value()      shift-in of the next dividend bit into the remainder
// ---------------------------------------------------------------------------
package div4_seq_pkg;

   localparam int unsigned DIV_WIDTH = 4;

   // Legacy-compatible state encoding.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [DIV_WIDTH-1:0] ZERO_DIV_QUOTIENT = 4'hF;

   // Iterations run from this counter value down to zero, one quotient bit each.
   localparam logic [1:0] ITER_START = 2'd3;

   typedef struct packed {
      logic [DIV_WIDTH-1:0] quotient;
      logic [DIV_WIDTH-1:0] remainder;
      logic                 div_by_zero;
   } div_result_t;

   // Trial value for one restoring step: the partial remainder shifted left by
   // one with the next dividend bit (the MSB of the shifting Q register)
   // brought in.  The remainder's MSB is always zero here because the partial
   // remainder never exceeds the dividend prefix, so dropping it loses nothing.
   function automatic logic [DIV_WIDTH-1:0] trial_value(
      input logic [DIV_WIDTH-1:0] r,
      input logic [DIV_WIDTH-1:0] q
   );
      return {r[DIV_WIDTH-2:0], q[DIV_WIDTH-1]};
   endfunction

endpackage

// File: rtl/div4_seq_addsub.sv
// ---------------------------------------------------------------------------
// adder_cum_sub
//   4-bit ripple-carry add/subtract unit.  cin doubles as the mode select:
//     cin = 0 : s = a + b,      cout = carry out
//     cin = 1 : s = a - b,      cout = borrow (1 when a < b)
//
//   Ports:
//     a    in  4  first operand (minuend in subtract mode)
//     b    in  4  second operand (subtrahend in subtract mode)
//     cin  in  1  mode / carry-in
//     s    out 4  sum or difference, modulo 16
//     cout out 1  carry (add) or borrow (subtract)
// ---------------------------------------------------------------------------
module adder_cum_sub
   import div4_seq_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] a,
   input  logic [DIV_WIDTH-1:0] b,
   input  logic                 cin,
   output logic [DIV_WIDTH-1:0] s,
   output logic                 cout
);

   logic [DIV_WIDTH-1:0] b_eff;
   logic [DIV_WIDTH:0]   carry;

   always_comb begin
      s     = '0;
      carry = '0;
      // Subtract is a + ~b + 1: invert b and use cin as the +1.
      b_eff    = b ^ {DIV_WIDTH{cin}};
      carry[0] = cin;
      for (int unsigned i = 0; i < DIV_WIDTH; i++) begin
         s[i]       = a[i] ^ b_eff[i] ^ carry[i];
         carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
      end
      // In subtract mode the raw carry is "no borrow"; flip it so cout reads
      // as borrow directly.
      cout = carry[DIV_WIDTH] ^ cin;
   end

endmodule

// File: rtl/div4_seq.sv
// ---------------------------------------------------------------------------
// div4_seq
//   Sequential 4-bit unsigned restoring divider, one quotient bit per clock,
//   MSB first.  Operands arrive over a valid/ready handshake; the result is
//   returned over a second valid/ready handshake and held until taken.
//
//   Ports:
//     clk          in  1  clock, all state on rising edge
//     rst          in  1  synchronous active-high reset
//     in_valid     in  1  dividend/divisor presented
//     in_ready     out 1  able to accept an operand pair (IDLE only)
//     dividend     in  4  unsigned dividend
//     divisor      in  4  unsigned divisor
//     out_valid    out 1  result registers hold a completed result (DONE)
//     out_ready    in  1  consumer takes the result
//     quotient     out 4  unsigned quotient (4'hF on divide by zero)
//     remainder    out 4  unsigned remainder (dividend on divide by zero)
//     div_by_zero  out 1  divisor was zero
//
//   Latency: nonzero divisor -> out_valid 4 cycles after accept; zero
//   divisor -> 1 cycle.  Result outputs only change on entry to DONE.
// ---------------------------------------------------------------------------
module div4_seq
   import div4_seq_pkg::*;
#(
   // Fixed by the add/subtract unit; other values are not supported.
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   logic [1:0]       state;
   logic [WIDTH-1:0] q_reg;   // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] r_reg;   // partial remainder
   logic [WIDTH-1:0] d_reg;   // divisor
   logic [1:0]       cnt;     // iterations remaining after the current one

   logic [WIDTH-1:0] trial;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             q_bit;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] r_next;

   // ------------------------------------------------------------------
   // Datapath: one restoring step per cycle through the shared subtractor.
   // ------------------------------------------------------------------
   always_comb begin
      trial = trial_value(r_reg, q_reg);
   end

   adder_cum_sub u_addsub (
      .a    (trial),
      .b    (d_reg),
      .cin  (1'b1),
      .s    (diff),
      .cout (borrow)
   );

   always_comb begin
      q_bit  = ~borrow;
      // On borrow the trial value is kept unchanged (restore).
      r_next = borrow ? trial : diff;
      q_next = {q_reg[WIDTH-2:0], q_bit};
   end

   // ------------------------------------------------------------------
   // Handshake outputs decode directly from the state register.
   // ------------------------------------------------------------------
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // ------------------------------------------------------------------
   // Controller and registers.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         q_reg       <= '0;
         r_reg       <= '0;
         d_reg       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  q_reg <= dividend;
                  d_reg <= divisor;
                  r_reg <= '0;
                  cnt   <= ITER_START;
                  state <= RUN;
               end
            end

            RUN: begin
               // A zero divisor spends exactly one cycle in RUN so that its
               // result appears one cycle after acceptance; Q still holds the
               // untouched dividend at this point.
               if (d_reg == '0) begin
                  quotient    <= ZERO_DIV_QUOTIENT;
                  remainder   <= q_reg;
                  div_by_zero <= 1'b1;
                  state       <= DONE;
               end else begin
                  q_reg <= q_next;
                  r_reg <= r_next;
                  cnt   <= cnt - 2'd1;
                  if (cnt == '0) begin
                     quotient    <= q_next;
                     remainder   <= r_next;
                     div_by_zero <= 1'b0;
                     state       <= DONE;
                  end
               end
            end

            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div4_seq.sv
module tb_div4_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] dividend;
   logic [3:0] divisor;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   div4_seq #(.WIDTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference arithmetic.
   function automatic void ref_div(input int dd, input int dv,
                                   output int q, output int r, output int z);
      if (dv == 0) begin
         q = 15; r = dd; z = 1;
      end else begin
         q = dd / dv; r = dd % dv; z = 0;
      end
   endfunction

   // Transaction-level model: an accepted pair becomes a visible result a fixed
   // number of cycles later, is held until taken, and the block is idle otherwise.
   bit         m_busy  = 1'b0;
   bit         m_valid = 1'b0;
   int         m_left  = 0;
   int         m_dd    = 0;
   int         m_dv    = 0;
   logic [3:0] m_q     = '0;
   logic [3:0] m_r     = '0;
   logic       m_z     = 1'b0;

   always @(posedge clk) begin
      int q, r, z;
      cyc++;
      if (rst) begin
         m_busy = 0; m_valid = 0; m_left = 0;
         m_q = '0; m_r = '0; m_z = 1'b0;
      end else if (m_valid) begin
         if (out_ready) m_valid = 0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            ref_div(m_dd, m_dv, q, r, z);
            m_q = q[3:0]; m_r = r[3:0]; m_z = z[0];
            m_busy = 0; m_valid = 1;
         end
      end else if (in_valid) begin
         m_dd = int'(dividend); m_dv = int'(divisor);
         m_left = (divisor == 4'd0) ? 1 : 4;
         m_busy = 1;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("mon_in_ready", in_ready, !(m_busy || m_valid));
         check("mon_out_valid", out_valid, m_valid);
         check("mon_quotient", quotient, m_q);
         check("mon_remainder", remainder, m_r);
         check("mon_div_by_zero", div_by_zero, m_z);
      end
   end

   // Present one pair (caller is 1 time unit after a rising edge, block idle),
   // wait a bounded time for the result and compare it with literal values.
   task automatic run_op(input logic [3:0] dd, input logic [3:0] dv,
                         input int exp_q, input int exp_r, input int exp_z,
                         output int acc_cyc, output int valid_cyc);
      int lat;
      int exp_lat;
      bit seen;
      check($sformatf("accept_ready_%0d_%0d", dd, dv), in_ready, 1);
      in_valid = 1'b1; dividend = dd; divisor = dv;
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      exp_lat  = (dv == 4'd0) ? 1 : 4;
      lat      = 0;
      seen     = 0;
      while (!seen && lat < 20) begin
         if (out_valid === 1'b1) seen = 1;
         else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      valid_cyc = cyc;
      check($sformatf("latency_%0d_%0d", dd, dv), lat, exp_lat);
      if (seen) begin
         check($sformatf("quotient_%0d_%0d", dd, dv), quotient, exp_q);
         check($sformatf("remainder_%0d_%0d", dd, dv), remainder, exp_r);
         check($sformatf("dbz_%0d_%0d", dd, dv), div_by_zero, exp_z);
         if (out_ready) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a1, v1, a2, v2, q, r, z;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      dividend = '0; divisor = '0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset state.
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);

      // 13/4.
      run_op(4'd13, 4'd4, 3, 1, 0, a1, v1);

      // 15/1 then 15/15 back to back with out_ready held high.
      run_op(4'd15, 4'd1, 15, 0, 0, a1, v1);
      run_op(4'd15, 4'd15, 1, 0, 0, a2, v2);
      check("b2b_accept_gap", a2 - v1, 2);
      check("b2b_period", a2 - a1, 6);

      // 7/0.
      run_op(4'd7, 4'd0, 15, 7, 1, a1, v1);

      // 9/11 held while out_ready is low; in_valid pulses must be ignored.
      out_ready = 1'b0;
      run_op(4'd9, 4'd11, 0, 9, 0, a1, v1);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         dividend = 4'(i + 3);
         divisor  = 4'(i + 1);
         @(posedge clk); #1;
         check("hold_quotient", quotient, 0);
         check("hold_remainder", remainder, 9);
         check("hold_out_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_out_valid", out_valid, 0);
      check("release_in_ready", in_ready, 1);

      // Reset during iteration 2 of 14/3.
      in_valid = 1'b1; dividend = 4'd14; divisor = 4'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      run_op(4'd14, 4'd3, 4, 2, 0, a1, v1);

      // All 256 operand pairs.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            ref_div(a, b, q, r, z);
            run_op(4'(a), 4'(b), q, r, z, a1, v1);
         end
      end

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
